// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for NUM_DIGITS common-anode
// seven-segment digits. A pending image is captured on load and committed
// to the display register only when the scan wraps, so a frame never tears.
// Optional build macro: SEVEN_SEG_LZ_BLANK_EN enables leading-zero suppression.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] dataIn,
  input  logic [NUM_DIGITS-1:0]   blankIn,
  input  logic [NUM_DIGITS-1:0]   dpIn,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [7:0]              cathodes,
  output logic                    updatePending,
  output logic                    frameTick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  // Active-low {dp,g,f,e,d,c,b,a} pattern for a hex nibble, dp off.
  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    term, wrap;

  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pending_q, pending_d;

  logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;

  logic                    tick_q;
  logic [NUM_DIGITS-1:0]   supp;
  logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
  logic [7:0]              cathodes_q, cathodes_d;

  // Slot prescaler and digit index; wrap marks the last cycle of a frame.
  always_comb begin
    term    = (presc_q == PRESC_MAX);
    wrap    = term && (idx_q == IDX_MAX);
    presc_d = term ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (term) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Pending buffer capture and frame-boundary commit; a load in the wrap
  // cycle bypasses the pending buffer and goes straight to the display.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_blank_d = pend_blank_q;
    pend_dp_d    = pend_dp_q;
    pending_d    = pending_q;
    disp_data_d  = disp_data_q;
    disp_blank_d = disp_blank_q;
    disp_dp_d    = disp_dp_q;
    if (load) begin
      pend_data_d  = dataIn;
      pend_blank_d = blankIn;
      pend_dp_d    = dpIn;
      pending_d    = 1'b1;
    end
    if (wrap) begin
      pending_d = 1'b0;
      if (load) begin
        disp_data_d  = dataIn;
        disp_blank_d = blankIn;
        disp_dp_d    = dpIn;
      end else if (pending_q) begin
        disp_data_d  = pend_data_q;
        disp_blank_d = pend_blank_q;
        disp_dp_d    = pend_dp_q;
      end
    end
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // Leading-zero mask: digit i>=1 is dark when it and every higher digit
  // hold 0 with no decimal point; taken from the committed image only.
  always_comb begin
    logic zrun;
    zrun = 1'b1;
    supp = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zrun    = zrun && (disp_data_q[4*i +: 4] == 4'h0) && !disp_dp_q[i];
      supp[i] = zrun;
    end
  end
`else
  // No leading-zero suppression: zeros display as "0".
  always_comb begin
    supp = '0;
  end
`endif

  // Pin pattern for the current digit; blanked digits leave all pins high.
  always_comb begin
    anodes_d   = '1;
    cathodes_d = 8'hFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((idx_q == IW'(i)) && !(disp_blank_q[i] || supp[i])) begin
        anodes_d[i] = 1'b0;
        cathodes_d  = hex_seg(disp_data_q[4*i +: 4]);
        if (disp_dp_q[i]) begin
          cathodes_d[7] = 1'b0;
        end
      end
    end
  end

  // State registers; reset leaves the display dark with nothing pending.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_blank_q <= '1;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      disp_data_q  <= '0;
      disp_blank_q <= '1;
      disp_dp_q    <= '0;
      tick_q       <= 1'b0;
      anodes_q     <= '1;
      cathodes_q   <= 8'hFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_blank_q <= pend_blank_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      disp_data_q  <= disp_data_d;
      disp_blank_q <= disp_blank_d;
      disp_dp_q    <= disp_dp_d;
      tick_q       <= wrap;
      anodes_q     <= anodes_d;
      cathodes_q   <= cathodes_d;
    end
  end

  assign anodes        = anodes_q;
  assign cathodes      = cathodes_q;
  assign updatePending = pending_q;
  assign frameTick     = tick_q;

endmodule
